// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-outstanding memory read port
//
// Purpose:
//   Two requesters share one memory read channel. One transaction is in flight
//   at a time: IDLE (arbitrate) -> ISSUE (present request) -> WAIT (collect
//   memory data) -> RESP (hand data back to the granted requester).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   rN_req_valid_i/rN_req_ready_o requester N request handshake
//   rN_addr_i                     requester N read address
//   rN_resp_valid_o/rN_resp_ready_i requester N response handshake
//   rN_data_o                     response data (shared data register)
//   mem_req_valid_o/mem_req_ready_i memory request handshake
//   mem_addr_o                    latched request address
//   mem_resp_valid_i/mem_resp_ready_o memory response handshake
//   mem_data_i                    memory read data
//   grant_o                       requester owning the current transaction
//   busy_o                        high whenever not IDLE
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req_valid_i,
    output logic              r0_req_ready_o,
    input  logic [ADDR_W-1:0] r0_addr_i,
    output logic              r0_resp_valid_o,
    input  logic              r0_resp_ready_i,
    output logic [DATA_W-1:0] r0_data_o,

    input  logic              r1_req_valid_i,
    output logic              r1_req_ready_o,
    input  logic [ADDR_W-1:0] r1_addr_i,
    output logic              r1_resp_valid_o,
    input  logic              r1_resp_ready_i,
    output logic [DATA_W-1:0] r1_data_o,

    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [DATA_W-1:0] mem_data_i,

    output logic              grant_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              any_valid;
    logic              winner;
    logic              granted_resp_ready;

    // Round-robin: a lone requester wins; on a tie the port that did not
    // finish the previous transaction wins.
    always_comb begin
        any_valid = r0_req_valid_i | r1_req_valid_i;
        if (r0_req_valid_i && r1_req_valid_i) begin
            winner = ~last_grant_q;
        end else begin
            winner = r1_req_valid_i & ~r0_req_valid_i;
        end
        granted_resp_ready = grant_q ? r1_resp_ready_i : r0_resp_ready_i;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                // The winner's ready is high whenever anyone is valid, so a
                // valid request in IDLE is always a handshake.
                if (any_valid) begin
                    state_d = ST_ISSUE;
                    grant_d = winner;
                    addr_d  = winner ? r1_addr_i : r0_addr_i;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    data_d  = mem_data_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (granted_resp_ready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    // Request readies are combinational from the valids, so they are gated
    // with rst to stay low while reset is held.
    assign r0_req_ready_o   = rst && (state_q == ST_IDLE) && any_valid && !winner;
    assign r1_req_ready_o   = rst && (state_q == ST_IDLE) && any_valid &&  winner;

    assign mem_req_valid_o  = (state_q == ST_ISSUE);
    assign mem_addr_o       = addr_q;
    assign mem_resp_ready_o = (state_q == ST_WAIT);

    assign r0_resp_valid_o  = (state_q == ST_RESP) && !grant_q;
    assign r1_resp_valid_o  = (state_q == ST_RESP) &&  grant_q;
    assign r0_data_o        = data_q;
    assign r1_data_o        = data_q;

    assign grant_o          = grant_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req_valid_i, r1_req_valid_i;
    logic        r0_req_ready_o, r1_req_ready_o;
    logic [31:0] r0_addr_i, r1_addr_i;
    logic        r0_resp_valid_o, r1_resp_valid_o;
    logic        r0_resp_ready_i, r1_resp_ready_i;
    logic [31:0] r0_data_o, r1_data_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i, mem_resp_ready_o;
    logic [31:0] mem_data_i;
    logic        grant_o, busy_o;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .r0_req_valid_i   (r0_req_valid_i),
        .r0_req_ready_o   (r0_req_ready_o),
        .r0_addr_i        (r0_addr_i),
        .r0_resp_valid_o  (r0_resp_valid_o),
        .r0_resp_ready_i  (r0_resp_ready_i),
        .r0_data_o        (r0_data_o),
        .r1_req_valid_i   (r1_req_valid_i),
        .r1_req_ready_o   (r1_req_ready_o),
        .r1_addr_i        (r1_addr_i),
        .r1_resp_valid_o  (r1_resp_valid_o),
        .r1_resp_ready_i  (r1_resp_ready_i),
        .r1_data_o        (r1_data_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_data_i       (mem_data_i),
        .grant_o          (grant_o),
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},        busy_o,           1'b0);
        check({tag, " mem_req_vld"}, mem_req_valid_o,  1'b0);
        check({tag, " mem_rsp_rdy"}, mem_resp_ready_o, 1'b0);
        check({tag, " r0_rsp_vld"},  r0_resp_valid_o,  1'b0);
        check({tag, " r1_rsp_vld"},  r1_resp_valid_o,  1'b0);
    endtask

    // Serve one transaction. Caller has the requester valids/addresses set and
    // the arbiter in IDLE; 'port' is the expected winner.
    task automatic serve(input int port, input logic [31:0] addr, input logic [31:0] rdata,
                         input int mem_delay, input int resp_delay);
        logic exp_r0, exp_r1;
        exp_r0 = (port == 0);
        exp_r1 = (port == 1);
        check("idle r0_req_rdy", r0_req_ready_o, exp_r0);
        check("idle r1_req_rdy", r1_req_ready_o, exp_r1);
        check("idle busy",       busy_o,         1'b0);
        tick();
        if (port == 0) r0_req_valid_i = 1'b0;
        else           r1_req_valid_i = 1'b0;
        #1;
        check("issue mem_req_vld", mem_req_valid_o, 1'b1);
        check("issue mem_addr",    mem_addr_o,      addr);
        check("issue grant",       grant_o,         port[0]);
        check("issue busy",        busy_o,          1'b1);
        check("issue r0_req_rdy",  r0_req_ready_o,  1'b0);
        check("issue r1_req_rdy",  r1_req_ready_o,  1'b0);
        check("issue mem_rsp_rdy", mem_resp_ready_o, 1'b0);
        for (int i = 0; i < mem_delay; i++) begin
            tick();
            check("stall mem_req_vld", mem_req_valid_o, 1'b1);
            check("stall mem_addr",    mem_addr_o,      addr);
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        #1;
        check("wait mem_req_vld", mem_req_valid_o,  1'b0);
        check("wait mem_rsp_rdy", mem_resp_ready_o, 1'b1);
        mem_resp_valid_i = 1'b1;
        mem_data_i       = rdata;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_data_i       = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i <= resp_delay; i++) begin
            if (i > 0) tick();
            check("resp r0_rsp_vld",  r0_resp_valid_o,  exp_r0);
            check("resp r1_rsp_vld",  r1_resp_valid_o,  exp_r1);
            check("resp r0_data",     r0_data_o,        rdata);
            check("resp r1_data",     r1_data_o,        rdata);
            check("resp mem_rsp_rdy", mem_resp_ready_o, 1'b0);
            check("resp r0_req_rdy",  r0_req_ready_o,   1'b0);
            check("resp r1_req_rdy",  r1_req_ready_o,   1'b0);
        end
        if (port == 0) r0_resp_ready_i = 1'b1;
        else           r1_resp_ready_i = 1'b1;
        tick();
        r0_resp_ready_i = 1'b0;
        r1_resp_ready_i = 1'b0;
        #1;
        check_idle_outputs("done");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst              = 1'b0;
        r0_req_valid_i   = 1'b0;
        r1_req_valid_i   = 1'b0;
        r0_addr_i        = '0;
        r1_addr_i        = '0;
        r0_resp_ready_i  = 1'b0;
        r1_resp_ready_i  = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;

        // Reset state, including readies held low despite a pending valid.
        tick();
        r0_req_valid_i = 1'b1;
        #1;
        check_idle_outputs("reset");
        check("reset r0_req_rdy", r0_req_ready_o, 1'b0);
        check("reset r1_req_rdy", r1_req_ready_o, 1'b0);
        check("reset grant",      grant_o,        1'b0);
        check("reset mem_addr",   mem_addr_o,     32'h0);
        check("reset r0_data",    r0_data_o,      32'h0);
        r0_req_valid_i = 1'b0;
        tick();
        rst = 1'b1;
        #1;

        // Single r0 read.
        r0_addr_i      = 32'h0000_0400;
        r0_req_valid_i = 1'b1;
        #1;
        serve(0, 32'h0000_0400, 32'h0000_0801, 0, 0);

        // Simultaneous requests after reset: r0, r1, then r0, r1 again.
        do_reset();
        r0_addr_i = 32'h0000_0800;
        r1_addr_i = 32'h0000_0804;
        r0_req_valid_i = 1'b1;
        r1_req_valid_i = 1'b1;
        #1;
        serve(0, 32'h0000_0800, 32'hA000_0800, 0, 0);
        serve(1, 32'h0000_0804, 32'hA000_0804, 0, 0);
        r0_req_valid_i = 1'b1;
        r1_req_valid_i = 1'b1;
        #1;
        serve(0, 32'h0000_0800, 32'hB000_0800, 0, 1);
        serve(1, 32'h0000_0804, 32'hB000_0804, 1, 0);

        // Memory stalls the request for 5 cycles.
        r0_addr_i      = 32'h0000_0010;
        r0_req_valid_i = 1'b1;
        #1;
        serve(0, 32'h0000_0010, 32'h1234_5678, 5, 0);

        // r1 response held 3 cycles while r0 waits; last grant was r0 so r1 wins.
        r0_addr_i      = 32'h0000_0030;
        r1_addr_i      = 32'h0000_0020;
        r0_req_valid_i = 1'b1;
        r1_req_valid_i = 1'b1;
        #1;
        serve(1, 32'h0000_0020, 32'h1100_000F, 0, 3);
        check("post r1 r0_req_rdy", r0_req_ready_o, 1'b1);
        serve(0, 32'h0000_0030, 32'h0000_0030, 0, 0);

        // Reset during WAIT, then a stray memory response after release.
        r0_addr_i      = 32'h0000_0040;
        r0_req_valid_i = 1'b1;
        tick();
        r0_req_valid_i  = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        #1;
        check("pre-rst mem_rsp_rdy", mem_resp_ready_o, 1'b1);
        rst = 1'b0;
        #1;
        check_idle_outputs("mid-rst");
        check("mid-rst grant",    grant_o,    1'b0);
        check("mid-rst mem_addr", mem_addr_o, 32'h0);
        tick();
        rst              = 1'b1;
        mem_resp_valid_i = 1'b1;
        mem_data_i       = 32'hDEAD_BEEF;
        tick();
        check_idle_outputs("stray1");
        check("stray r0_data", r0_data_o, 32'h0);
        mem_resp_valid_i = 1'b0;
        tick();
        check_idle_outputs("stray2");

        // Back-to-back r0 reads of unmapped address.
        r0_addr_i = 32'h0000_1000;
        for (int k = 0; k < 2; k++) begin
            r0_req_valid_i = 1'b1;
            #1;
            serve(0, 32'h0000_1000, 32'h0000_0000, 0, 0);
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter DATA_W, default 32, response data width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 r0_req_valid_i / r1_req_valid_i  input  1  requester 0/1 request valid.
REQ-006 r0_req_ready_o / r1_req_ready_o  output  1  requester 0/1 request accepted this cycle when high with valid.
REQ-007 r0_addr_i / r1_addr_i  input  ADDR_W  requester 0/1 address.
REQ-008 r0_resp_valid_o / r1_resp_valid_o  output  1  response valid to requester 0/1.
REQ-009 r0_resp_ready_i / r1_resp_ready_i  input  1  requester 0/1 accepts response.
REQ-010 r0_data_o / r1_data_o  output  DATA_W  both driven from the internal data register.
REQ-011 mem_req_valid_o  output  1  request to memory.
REQ-012 mem_req_ready_i  input  1  memory accepts request.
REQ-013 mem_addr_o  output  ADDR_W  latched address to memory.
REQ-014 mem_resp_valid_i  input  1  memory response valid.
REQ-015 mem_resp_ready_o  output  1  arbiter accepts memory response.
REQ-016 mem_data_i  input  DATA_W  memory read data.
REQ-017 grant_o  output  1  index of the requester owning the current transaction.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-020 IDLE: winner chosen combinationally from valid inputs; only the winner's req_ready_o is high; all req_ready_o are 0 outside IDLE.
REQ-021 Arbitration is round-robin: single valid wins; both valid -> port other than last_grant wins.
REQ-022 Request handshake (valid & ready) in IDLE latches addr, sets grant_o, moves to ISSUE next cycle.
REQ-023 ISSUE: mem_req_valid_o=1, mem_addr_o stable; on mem_req_ready_i=1 -> WAIT; valid held until accepted regardless of ready delay.
REQ-024 WAIT: mem_resp_ready_o=1; on mem_resp_valid_i=1 latch mem_data_i into data register -> RESP.
REQ-025 mem_resp_ready_o=0 in IDLE, ISSUE and RESP; a mem_resp_valid_i in those states is ignored.
REQ-026 RESP: resp_valid_o high only for the granted port; data held; on that port's resp_ready_i -> IDLE and last_grant <= grant_o.
REQ-027 Latency: request handshake at edge N -> mem_req_valid_o at N+1; memory response handshake at edge M -> resp_valid_o at M+1; next request acceptable at the cycle after the response handshake.
REQ-028 A requester dropping valid before handshake leaves state unchanged; the other port is then eligible.
REQ-029 Non-granted port's resp_ready_i and req_valid_i have no effect outside IDLE.
REQ-030 Address and data pass through unmodified; no width conversion.

Reset
REQ-031 rst low asynchronously forces IDLE, last_grant=1 (port 0 wins first tie), grant_o=0, data register=0, address register=0.
REQ-032 During reset all valid/ready outputs and busy_o are 0; reset mid-transaction abandons it without emitting any response.
REQ-033 First rising edge with rst high resumes normal IDLE operation.

Verification
REQ-034 Reset, then r0 alone reads 0x400, memory returns 0x00000801 -> r0_resp_valid_o with 0x00000801; r1_resp_valid_o never high.
REQ-035 Both valid same cycle after reset (r0 0x800, r1 0x804) -> r0 served first, then r1; next simultaneous pair served r0, r1 again alternating per round-robin.
REQ-036 mem_req_ready_i held 0 for 5 cycles in ISSUE -> mem_req_valid_o and mem_addr_o stable for all 5 cycles, single memory request issued.
REQ-037 r1_resp_ready_i held 0 for 3 cycles in RESP -> r1_resp_valid_o and data (0x1100000F) stable; r0 request pending meanwhile not accepted until after r1 handshake.
REQ-038 rst asserted during WAIT -> all outputs 0 immediately; late mem_resp_valid_i after release produces no requester response.
REQ-039 Back-to-back r0 requests with r1 idle -> each accepted one cycle after previous response handshake, 0x00000000 returned for unmapped 0x00001000.
